// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared NoC packet layout, generator FSM states and LFSR helpers.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int NOC_ADDR_W = 4;
    localparam int NOC_DATA_W = 24;

    typedef struct packed {
        logic                  ptype;
        logic [NOC_ADDR_W-1:0] dest;
        logic [NOC_ADDR_W-1:0] src;
        logic [NOC_DATA_W-1:0] data;
    } noc_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } noc_state_t;

    localparam int c_mode_rr_bit   = 0;
    localparam int c_mode_lfsr_bit = 1;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] c_lfsr_poly = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_poly : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_lfsr32.sv
`default_nettype none
// ============================================================================
// Module   : noc_lfsr32
// Brief    : 32-bit Galois LFSR with seed load and step enable.
// Revision : 1.0
// ============================================================================
module noc_lfsr32
    import noc_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_ACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state,
    output logic [31:0] next_state
);

    assign next_state = lfsr_step(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= seed;
        end else if (enable) begin
            state <= next_state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_gen
// Brief    : Programmable burst packet source driving one NoC PE input port.
// Revision : 1.0
// ============================================================================
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter  int          ADDR_W    = 4,
    parameter  int          DATA_W    = 24,
    parameter  int          NUM_DEST  = 4,
    parameter  int          CNT_W     = 16,
    parameter  int          GAP_W     = 8,
    parameter  logic [31:0] LFSR_SEED = 32'h0000_ACE1,
    localparam int          PKT_W     = 1 + 2*ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              pkt_type,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dest_base,
    input  logic [CNT_W-1:0]  num_pkts,
    input  logic [GAP_W-1:0]  gap,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count
);

    localparam logic [ADDR_W-1:0] c_idx_last = ADDR_W'(NUM_DEST - 1);

    noc_state_t        r_state;
    logic [1:0]        r_mode;
    logic              r_type;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dest_base;
    logic [CNT_W-1:0]  r_num;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_pay_cnt;

    logic              w_xfer;
    logic              w_lfsr_load;
    logic [31:0]       w_lfsr_state;
    logic [31:0]       w_lfsr_next;
    logic              w_unused_lfsr;
    logic [CNT_W-1:0]  w_sent_inc;
    logic              w_last;
    logic [ADDR_W-1:0] w_idx_next;
    logic [ADDR_W-1:0] w_dest_next;
    logic [DATA_W-1:0] w_pay_cnt_next;
    logic [DATA_W-1:0] w_payload_next;
    logic [DATA_W-1:0] w_payload_first;

    assign w_xfer          = pkt_valid & pkt_ready;
    assign w_lfsr_load     = start & (r_state == ST_IDLE);
    assign w_sent_inc      = sent_count + 1'b1;
    assign w_last          = (w_sent_inc == r_num);
    assign w_idx_next      = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    assign w_dest_next     = r_dest_base + (r_mode[c_mode_rr_bit] ? w_idx_next : '0);
    assign w_pay_cnt_next  = r_pay_cnt + 1'b1;
    assign w_payload_next  = r_mode[c_mode_lfsr_bit] ? w_lfsr_next[DATA_W-1:0] : w_pay_cnt_next;
    assign w_payload_first = mode[c_mode_lfsr_bit] ? LFSR_SEED[DATA_W-1:0] : '0;
    assign w_unused_lfsr   = ^{w_lfsr_state, w_lfsr_next};

    noc_lfsr32 #(
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .enable     (w_xfer),
        .load       (w_lfsr_load),
        .seed       (LFSR_SEED),
        .state      (w_lfsr_state),
        .next_state (w_lfsr_next)
    );

    // pkt_data always holds the packet to offer next, prepared on the previous transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= '0;
            r_type      <= 1'b0;
            r_src       <= '0;
            r_dest_base <= '0;
            r_num       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_idx       <= '0;
            r_pay_cnt   <= '0;
            pkt_valid   <= 1'b0;
            pkt_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_count  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_type      <= pkt_type;
                        r_src       <= src_addr;
                        r_dest_base <= dest_base;
                        r_num       <= num_pkts;
                        r_gap       <= gap;
                        r_idx       <= '0;
                        r_pay_cnt   <= '0;
                        sent_count  <= '0;
                        if (num_pkts != '0) begin
                            r_state   <= ST_SEND;
                            pkt_valid <= 1'b1;
                            busy      <= 1'b1;
                            pkt_data  <= {pkt_type, dest_base, src_addr, w_payload_first};
                        end else begin
                            r_state <= ST_FIN;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        sent_count <= w_sent_inc;
                        r_idx      <= w_idx_next;
                        r_pay_cnt  <= w_pay_cnt_next;
                        pkt_data   <= {r_type, w_dest_next, r_src, w_payload_next};
                        if (w_last) begin
                            r_state   <= ST_FIN;
                            pkt_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (r_gap != '0) begin
                            r_state   <= ST_GAP;
                            pkt_valid <= 1'b0;
                            r_gap_cnt <= r_gap;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state   <= ST_SEND;
                        pkt_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_traffic_gen
// Brief    : Scoreboard bench for noc_traffic_gen bursts, stalls, gaps, reset.
// Revision : 1.0
// ============================================================================
module tb_noc_traffic_gen;
    import noc_pkg::*;

    localparam int PKT_W = 33;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = '0;
    logic             pkt_type = 1'b0;
    logic [3:0]       src_addr = '0;
    logic [3:0]       dest_base = '0;
    logic [15:0]      num_pkts = '0;
    logic [7:0]       gap = '0;
    logic             pkt_valid;
    logic             pkt_ready = 1'b1;
    logic [PKT_W-1:0] pkt_data;
    logic             busy;
    logic             done;
    logic [15:0]      sent_count;

    int checks = 0;
    int errors = 0;
    logic [PKT_W-1:0] exp_q[$];

    int vcnt, first_v, done_cyc, unstable, busy_bad, timed_out;

    noc_traffic_gen #(
        .ADDR_W    (4),
        .DATA_W    (24),
        .NUM_DEST  (4),
        .CNT_W     (16),
        .GAP_W     (8),
        .LFSR_SEED (32'h0000_ACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .pkt_type   (pkt_type),
        .src_addr   (src_addr),
        .dest_base  (dest_base),
        .num_pkts   (num_pkts),
        .gap        (gap),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mk(input logic t, input logic [3:0] d,
                                            input logic [3:0] s, input logic [23:0] p);
        noc_pkt_t x;
        x.ptype = t;
        x.dest  = d;
        x.src   = s;
        x.data  = p;
        return x;
    endfunction

    // Scoreboard: every accepted packet must match the next expected entry
    always @(negedge clk) begin
        if (!rst && pkt_valid && pkt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt got %h exp none", pkt_data);
            end else begin
                logic [PKT_W-1:0] e;
                e = exp_q.pop_front();
                if (pkt_data !== e) begin
                    errors++;
                    $display("FAIL pkt_data got %h exp %h", pkt_data, e);
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic t, input logic [3:0] s,
                            input logic [3:0] b, input logic [15:0] n, input logic [7:0] g);
        @(posedge clk); #1;
        start = 1'b1; mode = m; pkt_type = t; src_addr = s; dest_base = b; num_pkts = n; gap = g;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; pkt_type = ~t; src_addr = ~s; dest_base = ~b;
        num_pkts = n + 16'd7; gap = g + 8'd5;
    endtask

    // Cycle 1 is the first cycle after the start edge; ready dropped for stall_len cycles from stall_from
    task automatic run_burst(input int budget, input int stall_from, input int stall_len);
        logic prev_stall;
        logic [PKT_W-1:0] prev_data;
        vcnt = 0; first_v = -1; done_cyc = -1; unstable = 0; busy_bad = 0;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (prev_stall && (!pkt_valid || pkt_data !== prev_data)) unstable = 1;
            if (pkt_valid) begin
                vcnt++;
                if (first_v < 0) first_v = c;
            end
            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
            if (done) begin
                done_cyc = c;
                if (busy) busy_bad = 1;
                break;
            end
            if (!busy) busy_bad = 1;
            @(posedge clk); #1;
            pkt_ready = !((c + 1) >= stall_from && (c + 1) < stall_from + stall_len);
        end
        pkt_ready = 1'b1;
        timed_out = (done_cyc < 0) ? 1 : 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", pkt_valid); end
        checks++; if (pkt_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", pkt_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (sent_count !== '0) begin errors++; $display("FAIL rst_sent got %0d exp 0", sent_count); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fixed_inc;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 4'hA, 4'hD, 24'(i)));
        do_start(2'b00, 1'b1, 4'hD, 4'hA, 16'd3, 8'd0);
        run_burst(50, 0, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL fixed_timeout got %0d exp 0", timed_out); end
        checks++; if (first_v != 1) begin errors++; $display("FAIL fixed_latency got %0d exp 1", first_v); end
        checks++; if (vcnt != 3) begin errors++; $display("FAIL fixed_valid_cycles got %0d exp 3", vcnt); end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL fixed_done_cycle got %0d exp 4", done_cyc); end
        checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL fixed_sent got %0d exp 3", sent_count); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL fixed_busy got %0d exp 0", busy_bad); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fixed_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 4'hE + 4'(i % 4), 4'h3, 24'(i)));
        do_start(2'b01, 1'b0, 4'h3, 4'hE, 16'd5, 8'd0);
        run_burst(50, 0, 0);
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL rr_done_cycle got %0d exp 6", done_cyc); end
        checks++; if (sent_count !== 16'd5) begin errors++; $display("FAIL rr_sent got %0d exp 5", sent_count); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 4'h4, 4'h8, 24'(i)));
        do_start(2'b00, 1'b1, 4'h8, 4'h4, 16'd3, 8'd0);
        run_burst(60, 2, 7);
        checks++; if (vcnt != 10) begin errors++; $display("FAIL bp_valid_cycles got %0d exp 10", vcnt); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stall_stable got %0d exp 0", unstable); end
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL bp_done_cycle got %0d exp 11", done_cyc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_gap_lfsr;
        exp_q.push_back(mk(1'b1, 4'h5, 4'h2, 24'h00ACE1));
        exp_q.push_back(mk(1'b1, 4'h5, 4'h2, 24'h205673));
        do_start(2'b10, 1'b1, 4'h2, 4'h5, 16'd2, 8'd3);
        run_burst(50, 0, 0);
        checks++; if (vcnt != 2) begin errors++; $display("FAIL gap_valid_cycles got %0d exp 2", vcnt); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL gap_done_cycle got %0d exp 6", done_cyc); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL gap_busy got %0d exp 0", busy_bad); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gap_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_edge_starts;
        do_start(2'b00, 1'b0, 4'h1, 4'h1, 16'd0, 8'd0);
        run_burst(20, 0, 0);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", vcnt); end
        checks++; if (sent_count !== '0) begin errors++; $display("FAIL zero_sent got %0d exp 0", sent_count); end
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 4'h6, 4'h9, 24'(i)));
        do_start(2'b00, 1'b0, 4'h9, 4'h6, 16'd3, 8'd2);
        do_start(2'b01, 1'b1, 4'hF, 4'h0, 16'd9, 8'd0);
        run_burst(100, 0, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL restart_timeout got %0d exp 0", timed_out); end
        checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL restart_sent got %0d exp 3", sent_count); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        exp_q.push_back(mk(1'b1, 4'h2, 4'h7, 24'd0));
        exp_q.push_back(mk(1'b1, 4'h3, 4'h7, 24'd1));
        do_start(2'b01, 1'b1, 4'h7, 4'h2, 16'd4, 8'd3);
        repeat (6) @(negedge clk);
        checks++; if (sent_count !== 16'd2) begin errors++; $display("FAIL mid_sent got %0d exp 2", sent_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", pkt_valid); end
        checks++; if (pkt_data !== '0) begin errors++; $display("FAIL mrst_data got %h exp 0", pkt_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy); end
        checks++; if (sent_count !== '0) begin errors++; $display("FAIL mrst_sent got %0d exp 0", sent_count); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mrst_left got %0d exp 0", exp_q.size()); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mk(1'b1, 4'h2, 4'h7, 24'd0));
        exp_q.push_back(mk(1'b1, 4'h3, 4'h7, 24'd1));
        do_start(2'b01, 1'b1, 4'h7, 4'h2, 16'd2, 8'd0);
        run_burst(50, 0, 0);
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL replay_done_cycle got %0d exp 3", done_cyc); end
        checks++; if (sent_count !== 16'd2) begin errors++; $display("FAIL replay_sent got %0d exp 2", sent_count); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL replay_left got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_fixed_inc;
        test_round_robin;
        test_backpressure;
        test_gap_lfsr;
        test_edge_starts;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
